// File: rtl/sprite_rom_arbiter_if.sv
// Purpose: request/grant/ROM/response bundle between the sprite requesters and the ROM arbiter.
// Latency: none, wires only.
// Backpressure: none; a requester holds req until it sees its gnt bit.
// Ports: req/req_addr from requesters, rom_q from ROM; gnt, rom_address, rdata, rvalid, busy to them.
interface sprite_rom_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 14,
   parameter int DATA_W  = 4
);
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ-1:0]        gnt;
   logic [ADDR_W-1:0]         rom_address;
   logic [DATA_W-1:0]         rom_q;
   logic [DATA_W-1:0]         rdata;
   logic [NUM_REQ-1:0]        rvalid;
   logic                      busy;

   // Arbiter side.
   modport slave (
      input  req, req_addr, rom_q,
      output gnt, rom_address, rdata, rvalid, busy
   );

   // Requester + ROM side.
   modport master (
      output req, req_addr, rom_q,
      input  gnt, rom_address, rdata, rvalid, busy
   );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Purpose: round-robin arbiter sharing one clocked sprite ROM port among NUM_REQ requesters.
// Latency: gnt/rom_address combinational in grant cycle N; rdata/rvalid registered in cycle N+2.
// Backpressure: none on responses; losers keep req high and are served as the pointer rotates.
// Ports: vga_clk, reset_n (sync, active-low), bus (slave modport: req, req_addr, rom_q in;
//        gnt, rom_address, rdata, rvalid, busy out).
module sprite_rom_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 14,
   parameter int DATA_W  = 4
) (
   input logic                 vga_clk,
   input logic                 reset_n,
   sprite_rom_arbiter_if.slave bus
);
   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [NUM_REQ-1:0] gnt_d;
   logic [NUM_REQ-1:0] tag1_q;   // grant seen last cycle: ROM is reading its address
   logic [NUM_REQ-1:0] tag2_q;   // owner of rdata this cycle
   logic [DATA_W-1:0]  rdata_q;

   // Round-robin search starting at ptr_q; first asserted request wins.
   always_comb begin : arb_c
      int idx;
      idx    = 0;
      gnt_d  = '0;
      ptr_d  = ptr_q;
      addr_d = addr_q;
      if (reset_n) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr_q) + i) % NUM_REQ;
            if (gnt_d == '0 && bus.req[idx]) begin
               gnt_d[idx] = 1'b1;
               addr_d     = bus.req_addr[idx*ADDR_W +: ADDR_W];
               ptr_d      = PTR_W'((idx + 1) % NUM_REQ);
            end
         end
      end
   end

   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         ptr_q   <= '0;
         addr_q  <= '0;
         tag1_q  <= '0;
         tag2_q  <= '0;
         rdata_q <= '0;
      end else begin
         ptr_q  <= ptr_d;
         addr_q <= addr_d;
         tag1_q <= gnt_d;
         tag2_q <= tag1_q;
         // ROM data for last cycle's grant is valid now; capture it only then so rdata holds otherwise.
         if (|tag1_q) begin
            rdata_q <= bus.rom_q;
         end
      end
   end

   assign bus.gnt         = gnt_d;
   assign bus.rom_address = addr_d;
   assign bus.rdata       = rdata_q;
   // Masked by reset so a response already in the output register is dropped in the reset cycle itself.
   assign bus.rvalid      = reset_n ? tag2_q : '0;
   assign bus.busy        = (|tag1_q) | (|tag2_q);
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Purpose: scoreboard bench for sprite_rom_arbiter with a behavioural clocked ROM.
// Latency: checks gnt/rom_address/busy each cycle and rvalid/rdata exactly two cycles after each grant.
// Backpressure: not applicable; directed request vectors with hand-computed grants.
module tb_sprite_rom_arbiter;
   logic vga_clk = 1'b0;
   logic reset_n;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   sprite_rom_arbiter_if #(.NUM_REQ(4), .ADDR_W(14), .DATA_W(4)) bus ();

   sprite_rom_arbiter #(.NUM_REQ(4), .ADDR_W(14), .DATA_W(4)) dut (
      .vga_clk (vga_clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 vga_clk = ~vga_clk;

   typedef struct {
      int         cyc;
      logic [3:0] id;
      logic [3:0] dat;
   } exp_t;

   exp_t        sb[$];
   logic [13:0] addr[4];
   logic [13:0] last_addr = '0;
   logic [3:0]  last_rdata = '0;
   bit          h1 = 0;
   bit          h2 = 0;

   // ROM contents: chosen so that address 0x0123 holds 0x5.
   function automatic logic [3:0] rom_fn(input logic [13:0] a);
      return a[3:0] ^ a[7:4] ^ a[11:8] ^ 4'h5;
   endfunction

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at cycle %0d", nm, act, want, cyc);
      end
   endfunction

   // Clocked ROM model and cycle counter.
   always @(posedge vga_clk) begin
      cyc       <= cyc + 1;
      bus.rom_q <= rom_fn(bus.rom_address);
   end

   // Monitor: pops the scoreboard when a response is due, otherwise expects no rvalid and held rdata.
   always @(negedge vga_clk) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
         exp_t e;
         e = sb.pop_front();
         chk("rvalid", 32'(bus.rvalid), 32'(e.id));
         chk("rdata", 32'(bus.rdata), 32'(e.dat));
         last_rdata = e.dat;
      end else begin
         chk("rvalid_idle", 32'(bus.rvalid), 32'h0);
         if (reset_n) chk("rdata_hold", 32'(bus.rdata), 32'(last_rdata));
      end
      if (!reset_n) last_rdata = '0;
   end

   task automatic step(input logic rn, input logic [3:0] r, input logic [3:0] eg);
      logic [13:0] ea;
      @(posedge vga_clk);
      #1;
      reset_n      = rn;
      bus.req      = r;
      bus.req_addr = {addr[3], addr[2], addr[1], addr[0]};
      if (!rn) sb.delete();
      @(negedge vga_clk);
      chk("gnt", 32'(bus.gnt), 32'(eg));
      ea = last_addr;
      for (int i = 0; i < 4; i++) if (eg[i]) ea = addr[i];
      if (rn) begin
         chk("rom_address", 32'(bus.rom_address), 32'(ea));
         chk("busy", 32'(bus.busy), 32'(h1 | h2));
      end
      if (eg != 4'b0000) sb.push_back('{cyc + 2, eg, rom_fn(ea)});
      h2        = h1;
      h1        = (eg != 4'b0000);
      last_addr = ea;
      if (!rn) begin
         h1        = 0;
         h2        = 0;
         last_addr = '0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      logic [3:0] full_seq[8];
      full_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
      reset_n      = 1'b0;
      bus.req      = '0;
      bus.req_addr = '0;
      for (int i = 0; i < 4; i++) addr[i] = '0;

      // Reset: gnt stays low even with all requesting; post-reset state checked in the idle step.
      step(0, 4'b1111, 4'b0000);
      step(0, 4'b1111, 4'b0000);
      step(1, 4'b0000, 4'b0000);

      // Single read of 0x0123 returning 0x5.
      addr[0] = 14'h0123;
      step(1, 4'b0001, 4'b0001);
      repeat (3) step(1, 4'b0000, 4'b0000);

      // Full contention from reset.
      step(0, 4'b0000, 4'b0000);
      addr[0] = 14'h00A1; addr[1] = 14'h01B2; addr[2] = 14'h02C3; addr[3] = 14'h03D4;
      for (int i = 0; i < 8; i++) step(1, 4'b1111, full_seq[i]);

      // Sparse rotation: grant 1 -> ptr 2; req 0011 wraps to 0; ptr then 1.
      step(1, 4'b0010, 4'b0010);
      step(1, 4'b0011, 4'b0001);
      step(1, 4'b0011, 4'b0010);

      // Idle: busy drains, address and data hold.
      repeat (5) step(1, 4'b0000, 4'b0000);

      // Stream from a single requester with changing addresses.
      for (int i = 0; i < 10; i++) begin
         addr[2] = 14'h0200 + 14'(i) * 14'h0111;
         step(1, 4'b0100, 4'b0100);
      end

      // Pointer at 3 wraps to 0.
      step(1, 4'b1001, 4'b1000);
      step(1, 4'b1001, 4'b0001);

      // Mid-flight reset discards both reads; requester 0 has priority afterwards.
      step(1, 4'b0001, 4'b0001);
      step(1, 4'b0010, 4'b0010);
      step(0, 4'b1111, 4'b0000);
      step(1, 4'b0000, 4'b0000);
      step(1, 4'b0000, 4'b0000);
      step(1, 4'b1001, 4'b0001);
      step(1, 4'b1001, 4'b1000);

      repeat (4) step(1, 4'b0000, 4'b0000);
      chk("sb_drain", 32'(sb.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sprite_rom_arbiter.md
SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
- REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  - NUM_REQ, 4, number of requesters sharing the sprite ROM port.
  - ADDR_W, 14, ROM address width.
  - DATA_W, 4, ROM palette-index width.
- REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
  - vga_clk, input, 1, single clock for all logic.
  - reset_n, input, 1, synchronous active-low reset.
  - req, input, NUM_REQ, per-requester read request, held until granted.
  - req_addr, input, NUM_REQ*ADDR_W, packed addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
  - gnt, output, NUM_REQ, one-hot grant, combinational in the request cycle.
  - rom_address, output, ADDR_W, address to the clocked sprite ROM.
  - rom_q, input, DATA_W, ROM data, valid one cycle after its address is sampled.
  - rdata, output, DATA_W, registered returned palette index.
  - rvalid, output, NUM_REQ, one-hot registered marker of which requester owns rdata.
  - busy, output, 1, high while any read is in flight.
- REQ-003 The block SHALL use one clock, vga_clk; reset_n SHALL be synchronous and active-low.

Function
- REQ-004 Arbitration SHALL be round-robin using a pointer ptr (0..NUM_REQ-1).
  - Search order: ptr, ptr+1, ... wrapping modulo NUM_REQ.
  - The first asserted req wins.
- REQ-005 At most one gnt bit SHALL be high per cycle; gnt SHALL be all-zero when req is all-zero or reset_n is low.
- REQ-006 When gnt[k] is high, ptr SHALL become (k+1) mod NUM_REQ at the clock edge; with no grant, ptr SHALL hold.
- REQ-007 rom_address SHALL equal the granted requester's req_addr slice in the grant cycle, and SHALL hold its previous value when there is no grant.
- REQ-008 Read latency SHALL be fixed at 2 cycles:
  - Grant in cycle N.
  - rom_q sampled at the end of cycle N+1.
  - rdata and rvalid[k] high in cycle N+2 only.
- REQ-009 Back-to-back grants SHALL be accepted every cycle, so there is one response per cycle with no bubbles.
  - An internal 2-stage one-hot tag pipeline carries the grant vector to rvalid.
- REQ-010 rvalid SHALL be all-zero in cycles without a matching grant two cycles earlier; rdata SHALL hold its last value when rvalid is zero.
- REQ-011 busy SHALL be the OR of the grant-tag stage-1 and stage-2 registers.
- REQ-012 A requester granted in cycle N that keeps req high in N+1 SHALL be treated as a new request, subject to the rotated ptr.
- REQ-013 Boundary behaviour:
  - All NUM_REQ requesting continuously SHALL yield grants k, k+1, ... cyclic, with no requester waiting more than NUM_REQ-1 cycles.
  - A single requester asserting continuously SHALL be granted every cycle.
  - ptr at NUM_REQ-1 SHALL wrap to 0.
- REQ-014 The block SHALL be purely synchronous, with no latches; outputs other than gnt and rom_address SHALL be registered.

Reset
- REQ-015 While reset_n is low at a clock edge, the following SHALL be cleared:
  - ptr to 0.
  - Tag pipeline to 0.
  - rvalid to 0, rdata to 0, rom_address to 0, busy to 0.
- REQ-016 Reset asserted mid-operation SHALL discard all in-flight reads: no rvalid pulse in the cycles after reset for grants issued before it.
- REQ-017 In the first cycle after reset_n rises, requester 0 SHALL have highest priority.

Verification
- REQ-018 Single read: req=0001, req_addr[0]=0x0123, rom_q=0x5 in cycle N+1 -> gnt=0001 in cycle N, rom_address=0x0123, rdata=0x5 and rvalid=0001 in cycle N+2.
- REQ-019 Full contention: req=1111 held for 8 cycles from reset -> gnt sequence 0001, 0010, 0100, 1000, 0001, 0010, 0100, 1000; rvalid follows the same sequence delayed 2 cycles.
- REQ-020 Sparse rotation: ptr=2 (after a grant to requester 1), req=0011 -> gnt=0001 (wraps past 2 and 3), next ptr=1.
- REQ-021 Mid-flight reset: grants in cycles 5 and 6, reset_n low in cycle 7 -> rvalid=0000 in cycles 7, 8 and 9; after release, req=1000 and req=0001 together -> gnt=0001.
- REQ-022 Idle: req=0000 for 5 cycles after traffic -> gnt=0000, busy falls 2 cycles after the last grant, rom_address and rdata unchanged.
- REQ-023 Stream: req=0100 held for 10 cycles with distinct addresses -> 10 consecutive rvalid=0100 pulses, each rdata matching the ROM contents at its address.
